// File: rtl/tpm_dispatch.sv
// tpm_dispatch: command dispatcher between a TPM-style register file and a
// bank of accelerator engines, with timeout, abort and bad-opcode handling.
module tpm_dispatch #(
  parameter int C_REG_SIZE = 32,
  parameter int C_NUM_ARGS = 8,
  parameter int C_NUM_ENG  = 4,
  parameter int C_TIMEOUT  = 1024
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [C_REG_SIZE-1:0]                  in_status,
  input  logic [C_NUM_ARGS*C_REG_SIZE-1:0]       in_args,
  output logic [C_REG_SIZE-1:0]                  out_status,
  output logic [C_NUM_ARGS*C_REG_SIZE-1:0]       out_args,
  output logic                                   reset_status,
  output logic [C_NUM_ENG-1:0]                   eng_start,
  output logic [C_NUM_ARGS*C_REG_SIZE-1:0]       eng_args,
  input  logic [C_NUM_ENG-1:0]                   eng_done,
  input  logic [C_NUM_ENG*C_NUM_ARGS*C_REG_SIZE-1:0] eng_result
);

  localparam int AW = C_NUM_ARGS * C_REG_SIZE;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_n;

  logic [4:0]           op_q;
  logic                 valid_q;
  logic                 err_q;
  logic [1:0]           code_q;
  logic [15:0]          cyc_q;
  logic [15:0]          cnt_q;
  logic [AW-1:0]        oargs_q;
  logic [AW-1:0]        eargs_q;
  logic [C_NUM_ENG-1:0] start_q;
  logic                 rs_q;

  logic                 in_valid;
  logic                 in_abort;
  logic [4:0]           in_op;
  logic                 op_ok;
  logic [16:0]          cur;
  logic [15:0]          cur_sat;
  logic                 act_done;
  logic [AW-1:0]        act_res;
  logic [C_NUM_ENG-1:0] start_n;
  logic                 acc;
  logic                 bad;
  logic                 fin_done;
  logic                 fin_abort;
  logic                 fin_to;
  logic [31:0]          st32;
  logic                 unused_bits;

  assign in_valid    = in_status[0];
  assign in_op       = in_status[5:1];
  assign in_abort    = in_status[6];
  assign unused_bits = ^in_status[C_REG_SIZE-1:7];
  assign op_ok       = {1'b0, in_op} < 6'(C_NUM_ENG);

  // cnt_q holds completed WAIT cycles; cur is the count for this cycle
  assign cur     = {1'b0, cnt_q} + 17'd1;
  assign cur_sat = cur[16] ? 16'hFFFF : cur[15:0];

  // select active engine's done/result and decode the incoming opcode
  always_comb begin
    act_done = 1'b0;
    act_res  = '0;
    start_n  = '0;
    for (int e = 0; e < C_NUM_ENG; e++) begin
      if (op_q == 5'(e)) begin
        act_done = eng_done[e];
        act_res  = eng_result[e*AW +: AW];
      end
      if (in_op == 5'(e)) start_n[e] = 1'b1;
    end
  end

  // next-state and event decode; done beats abort beats timeout
  always_comb begin
    state_n   = state;
    acc       = 1'b0;
    bad       = 1'b0;
    fin_done  = 1'b0;
    fin_abort = 1'b0;
    fin_to    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (op_ok) begin
            acc     = 1'b1;
            state_n = S_WAIT;
          end else begin
            bad = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (act_done) begin
          fin_done = 1'b1;
          state_n  = S_IDLE;
        end else if (in_abort) begin
          fin_abort = 1'b1;
          state_n   = S_IDLE;
        end else if (cur == 17'(C_TIMEOUT)) begin
          fin_to  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= S_IDLE;
    else        state <= state_n;
  end

  // datapath registers updated by the decoded events
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      op_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      oargs_q <= '0;
      eargs_q <= '0;
      start_q <= '0;
      rs_q    <= 1'b0;
    end else begin
      start_q <= '0;
      rs_q    <= 1'b0;
      if (acc) begin
        eargs_q <= in_args;
        op_q    <= in_op;
        start_q <= start_n;
        rs_q    <= 1'b1;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        code_q  <= 2'd0;
        cnt_q   <= '0;
      end
      if (bad) begin
        err_q   <= 1'b1;
        code_q  <= 2'd1;
        valid_q <= 1'b0;
        rs_q    <= 1'b1;
        op_q    <= in_op;
      end
      if (state == S_WAIT) cnt_q <= cur[15:0];
      if (fin_done) begin
        oargs_q <= act_res;
        valid_q <= 1'b1;
        cyc_q   <= cur_sat;
      end
      if (fin_abort) begin
        err_q  <= 1'b1;
        code_q <= 2'd3;
        rs_q   <= 1'b1;
        cyc_q  <= cur_sat;
      end
      if (fin_to) begin
        err_q  <= 1'b1;
        code_q <= 2'd2;
        cyc_q  <= 16'(C_TIMEOUT);
      end
    end
  end

  assign st32 = {cyc_q, 3'b000, op_q, 3'b000, code_q,
                 err_q, valid_q, (state == S_IDLE)};

  assign out_status   = C_REG_SIZE'(st32);
  assign out_args     = oargs_q;
  assign eng_args     = eargs_q;
  assign eng_start    = start_q;
  assign reset_status = rs_q;

endmodule

// File: doc/tpm_dispatch.md
TPM_DISPATCH -- requirements
Module: tpm_dispatch

Interface
REQ-001 Parameter C_REG_SIZE, default 32, sets the register width in bits.
REQ-002 Parameter C_NUM_ARGS, default 8, sets the argument registers per direction; legal range 1..16.
REQ-003 Parameter C_NUM_ENG, default 4, sets the accelerator channel count; legal range 1..32.
REQ-004 Parameter C_TIMEOUT, default 1024, sets the maximum wait cycles per command; legal range 2..65535.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port resetn, input, 1 bit: asynchronous active-high reset; high forces reset state immediately, regardless of clk.
REQ-007 Port in_status, input, C_REG_SIZE bits: [0] command valid, [5:1] opcode (engine index), [6] abort.
REQ-008 Port in_args, input, C_NUM_ARGS*C_REG_SIZE bits: command arguments, arg k at bits [k*C_REG_SIZE +: C_REG_SIZE].
REQ-009 Port out_status, output, C_REG_SIZE bits: [0] idle, [1] result valid, [2] error, [4:3] error code, [12:8] last opcode, [31:16] last command cycle count; other bits 0.
REQ-010 Port out_args, output, C_NUM_ARGS*C_REG_SIZE bits: result registers, same packing as in_args.
REQ-011 Port reset_status, output, 1 bit: one-cycle pulse telling the register file to clear in_status[0].
REQ-012 Port eng_start, output, C_NUM_ENG bits: one-hot, one-cycle start pulse per engine.
REQ-013 Port eng_args, output, C_NUM_ARGS*C_REG_SIZE bits: argument snapshot latched at command accept, shared by all engines.
REQ-014 Port eng_done, input, C_NUM_ENG bits: per-engine completion, sampled only in WAIT, only for the active engine.
REQ-015 Port eng_result, input, C_NUM_ENG*C_NUM_ARGS*C_REG_SIZE bits: per-engine result words; engine e occupies slice e*C_NUM_ARGS*C_REG_SIZE.

Function
REQ-016 The FSM SHALL have the states IDLE and WAIT only; out_status[0] SHALL equal (state==IDLE) combinationally.
REQ-017 In IDLE with in_status[0]=1 and opcode<C_NUM_ENG, the next edge SHALL: latch in_args into eng_args; latch the opcode into out_status[12:8]; set eng_start[opcode]=1 for exactly one cycle; pulse reset_status for one cycle; clear valid, error and error code; clear the cycle counter; enter WAIT.
REQ-018 In IDLE with in_status[0]=1 and opcode>=C_NUM_ENG, the next edge SHALL set error=1, code=1 (bad opcode), valid=0, pulse reset_status, latch the opcode, leave out_args unchanged and stay in IDLE; no eng_start bit asserts.
REQ-019 In IDLE with in_status[0]=0, all registers SHALL hold; eng_done and in_status[6] SHALL be ignored.
REQ-020 In WAIT the counter SHALL increment each cycle, starting at 1 on the first WAIT cycle.
REQ-021 In WAIT with eng_done[active]=1, the next edge SHALL copy the active engine's eng_result slice to out_args, set valid=1, write the counter to out_status[31:16] saturated at 0xFFFF, and return to IDLE; completion-to-valid latency is one cycle.
REQ-022 In WAIT, when the counter equals C_TIMEOUT without done, the next edge SHALL set error=1 and code=2 (timeout), keep valid=0 and out_args unchanged, write C_TIMEOUT to out_status[31:16], and return to IDLE.
REQ-023 In WAIT with in_status[6]=1 and no done, the next edge SHALL set error=1 and code=3 (aborted), pulse reset_status, and return to IDLE.
REQ-024 Priority on simultaneous events in WAIT SHALL be done, then abort, then timeout.
REQ-025 In WAIT, in_status[0] and eng_done of non-active engines SHALL be ignored; no second command queues.
REQ-026 A late eng_done arriving after a timeout or abort SHALL be ignored.
REQ-027 A command SHALL be accepted on the first IDLE cycle after a completion if in_status[0]=1; there is no dead cycle.

Reset
REQ-028 While resetn=1: state=IDLE; out_status[31:1]=0 with out_status[0]=1; out_args=0; eng_args=0; eng_start=0; reset_status=0; counter=0.
REQ-029 Reset asserted mid-WAIT SHALL abandon the command with no error recorded and no eng_start re-issued after release.

Verification
REQ-030 Opcode 0 command with args 0x11..0x88 and eng_done[0] three cycles after start, result 0xDEADBEEF -> eng_start=0001 for 1 cycle, eng_args matches, out_args[0]=0xDEADBEEF, valid=1, out_status[31:16]=3, idle=1.
REQ-031 Opcode 7 with C_NUM_ENG=4 -> error=1, code=1, reset_status pulse, eng_start=0 throughout, out_status[12:8]=7.
REQ-032 Opcode 2 with eng_done never asserted, C_TIMEOUT=16 -> IDLE after 16 WAIT cycles, code=2, out_status[31:16]=16; a later eng_done[2] changes nothing.
REQ-033 Abort and eng_done[1] in the same WAIT cycle -> done wins: valid=1, error=0; abort alone on a later command -> code=3.
REQ-034 Reset pulsed asynchronously mid-WAIT between clock edges -> outputs reach reset values before the next edge; next command after release behaves per REQ-030.
REQ-035 Back-to-back commands with in_status[0] held high across a completion -> second command accepted on the first IDLE cycle, with valid cleared at accept.
